xcorr_peak_detect: RTL and testbench

Sink for the serial output stream of the `xcorr` IFFT stage. It accepts one NFFT-sample complex cross-correlation frame and tracks the L1 magnitude peak on the fly. At frame end it reports the peak index, the peak magnitude and the equivalent signed lag. It sits directly after `xcorr` and replaces the bench-side file capture with a synthesizable lag estimator.

---
 rtl/xcorr_peak_detect.sv | 204 ++++++++++++++++++++
 tb/tb_xcorr_peak_detect.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xcorr_peak_detect.sv
// xcorr_peak_detect
//
// Streaming peak detector for the serial IFFT output of the xcorr stage. It accepts one
// NFFT-sample complex frame, tracks the largest L1 magnitude |re|+|im| as the samples arrive,
// and at frame end reports the peak index, the peak magnitude and the equivalent signed lag.
//
// Optional build feature: define XCORR_PEAK_BUF_EN to instantiate an NFFT-deep frame buffer
// that can be read back through rd_addr / rd_data_r / rd_data_i. Without it rd_data_* stay 0.
//
// Ports:
//   clk              - clock, rising edge
//   rst              - asynchronous active-high reset
//   serial_in_r/_i   - signed IFFT sample (real, imaginary)
//   data_valid_IFFT  - sample valid; end_IFFT is ignored when this is low
//   end_IFFT         - frame start marker, high together with sample 0
//   peak_valid       - one-cycle pulse, peak_* were just updated
//   peak_idx         - index of the peak sample
//   peak_lag         - signed lag (peak_idx, or peak_idx-NFFT for the upper half)
//   peak_mag         - |re|+|im| of the peak sample
//   frame_err        - one-cycle pulse, current frame aborted by an early start marker
//   busy             - high while collecting a frame
//   rd_addr          - frame buffer read address
//   rd_data_r/_i     - frame buffer read data, one cycle after rd_addr

module xcorr_peak_detect #(
    parameter int unsigned INTEGER_SIZE = 16,
    parameter int unsigned FRACT_SIZE   = 16,
    parameter int unsigned NFFT         = 128,
    localparam int unsigned DATA_WIDTH  = INTEGER_SIZE + FRACT_SIZE,
    localparam int unsigned AW          = $clog2(NFFT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] serial_in_r,
    input  logic signed [DATA_WIDTH-1:0] serial_in_i,
    input  logic                         data_valid_IFFT,
    input  logic                         end_IFFT,
    output logic                         peak_valid,
    output logic        [AW-1:0]         peak_idx,
    output logic signed [AW-1:0]         peak_lag,
    output logic        [DATA_WIDTH:0]   peak_mag,
    output logic                         frame_err,
    output logic                         busy,
    input  logic        [AW-1:0]         rd_addr,
    output logic        [DATA_WIDTH-1:0] rd_data_r,
    output logic        [DATA_WIDTH-1:0] rd_data_i
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StDone    = 2'd2
    } state_e;

    localparam logic [AW-1:0] LastIdx = AW'(NFFT - 1);

    state_e              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH:0] max_q, max_d;
    logic [AW-1:0]       max_idx_q, max_idx_d;
    logic [AW-1:0]       peak_idx_q, peak_idx_d;
    logic [DATA_WIDTH:0] peak_mag_q, peak_mag_d;
    logic                peak_valid_q, peak_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                busy_q, busy_d;

    // Absolute value widened by one bit so the most negative input maps exactly.
    function automatic logic [DATA_WIDTH:0] abs_ext(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH:0] xe;
        xe = {x[DATA_WIDTH-1], x};
        return x[DATA_WIDTH-1] ? (~xe + {{DATA_WIDTH{1'b0}}, 1'b1}) : xe;
    endfunction

    logic [DATA_WIDTH:0] mag;
    logic                start;
    logic                collect_step;
    logic                higher;

    // Sum of two values each <= 2^(DATA_WIDTH-1) always fits in DATA_WIDTH+1 bits.
    assign mag          = abs_ext(serial_in_r) + abs_ext(serial_in_i);
    assign start        = data_valid_IFFT & end_IFFT;
    assign collect_step = data_valid_IFFT & ~end_IFFT & (state_q == StCollect);
    // Strict compare: on ties the earliest index is kept.
    assign higher       = mag > max_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        max_d        = max_q;
        max_idx_d    = max_idx_q;
        peak_idx_d   = peak_idx_q;
        peak_mag_d   = peak_mag_q;
        peak_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Samples without a start marker are dropped here.
            end
            StCollect: begin
                if (start) begin
                    frame_err_d = (cnt_q != '0);
                end else if (collect_step) begin
                    cnt_d = cnt_q + AW'(1);
                    if (higher) begin
                        max_d     = mag;
                        max_idx_d = cnt_q;
                    end
                    if (cnt_q == LastIdx) begin
                        state_d      = StDone;
                        peak_valid_d = 1'b1;
                        peak_idx_d   = higher ? cnt_q : max_idx_q;
                        peak_mag_d   = higher ? mag : max_q;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A start marker in any state (re)seeds the frame with this sample as index 0.
        if (start) begin
            state_d   = StCollect;
            cnt_d     = AW'(1);
            max_d     = mag;
            max_idx_d = '0;
        end
    end

    assign busy_d = (state_d == StCollect);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            max_q        <= '0;
            max_idx_q    <= '0;
            peak_idx_q   <= '0;
            peak_mag_q   <= '0;
            peak_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            max_q        <= max_d;
            max_idx_q    <= max_idx_d;
            peak_idx_q   <= peak_idx_d;
            peak_mag_q   <= peak_mag_d;
            peak_valid_q <= peak_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign peak_valid = peak_valid_q;
    assign peak_idx   = peak_idx_q;
    // Two's-complement reinterpretation gives idx for the lower half and idx-NFFT above it.
    assign peak_lag   = $signed(peak_idx_q);
    assign peak_mag   = peak_mag_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

`ifdef XCORR_PEAK_BUF_EN
    logic [DATA_WIDTH-1:0] buf_r_mem [NFFT];
    logic [DATA_WIDTH-1:0] buf_i_mem [NFFT];
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] rd_data_r_q, rd_data_i_q;

    assign wr_en   = start | collect_step;
    assign wr_addr = start ? '0 : cnt_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_r_mem[wr_addr] <= serial_in_r;
            buf_i_mem[wr_addr] <= serial_in_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r_q <= '0;
            rd_data_i_q <= '0;
        end else begin
            rd_data_r_q <= buf_r_mem[rd_addr];
            rd_data_i_q <= buf_i_mem[rd_addr];
        end
    end

    assign rd_data_r = rd_data_r_q;
    assign rd_data_i = rd_data_i_q;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data_r      = '0;
    assign rd_data_i      = '0;
`endif

endmodule

// File: tb/tb_xcorr_peak_detect.sv
// Randomized self-checking bench for xcorr_peak_detect. The reference model keeps the
// current frame as a queue of magnitudes and scans it for the first maximum at frame end.

module tb_xcorr_peak_detect;

    localparam int NFFT = 128;
    localparam int AW   = 7;
    localparam int DW   = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic        [DW-1:0] serial_in_r, serial_in_i;
    logic                 data_valid_IFFT, end_IFFT;
    logic                 peak_valid;
    logic        [AW-1:0] peak_idx;
    logic signed [AW-1:0] peak_lag;
    logic        [DW:0]   peak_mag;
    logic                 frame_err, busy;
    logic        [AW-1:0] rd_addr;
    logic        [DW-1:0] rd_data_r, rd_data_i;

    always #5 clk = ~clk;

    xcorr_peak_detect #(
        .INTEGER_SIZE(16),
        .FRACT_SIZE  (16),
        .NFFT        (NFFT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .serial_in_r    (serial_in_r),
        .serial_in_i    (serial_in_i),
        .data_valid_IFFT(data_valid_IFFT),
        .end_IFFT       (end_IFFT),
        .peak_valid     (peak_valid),
        .peak_idx       (peak_idx),
        .peak_lag       (peak_lag),
        .peak_mag       (peak_mag),
        .frame_err      (frame_err),
        .busy           (busy),
        .rd_addr        (rd_addr),
        .rd_data_r      (rd_data_r),
        .rd_data_i      (rd_data_i)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    longint        fq[$];
    bit            in_frame = 0;
    longint        last_idx = 0;
    longint        last_mag = 0;
    logic [DW-1:0] mem_r [NFFT];
    logic [DW-1:0] mem_i [NFFT];
    logic [DW-1:0] fr_r [NFFT];
    logic [DW-1:0] fr_i [NFFT];

    function automatic longint mag_of(input logic [DW-1:0] r, input logic [DW-1:0] i);
        longint a, b;
        a = longint'($signed(r));
        b = longint'($signed(i));
        if (a < 0) a = -a;
        if (b < 0) b = -b;
        return a + b;
    endfunction

    // Present one cycle of input, advance the model, then check the registered outputs.
    task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] i, input logic v,
                        input logic e);
        bit     exp_pv, exp_err;
        longint lag_got, lag_exp;
        int     best;
        serial_in_r     = r;
        serial_in_i     = i;
        data_valid_IFFT = v;
        end_IFFT        = e;
        exp_pv          = 0;
        exp_err         = 0;
        if (v) begin
            if (e) begin
                if (in_frame) exp_err = 1;
                in_frame = 1;
                fq.delete();
            end
            if (in_frame) begin
                mem_r[fq.size()] = r;
                mem_i[fq.size()] = i;
                fq.push_back(mag_of(r, i));
            end
            if (in_frame && fq.size() == NFFT) begin
                best = 0;
                for (int j = 1; j < NFFT; j++) if (fq[j] > fq[best]) best = j;
                last_idx = best;
                last_mag = fq[best];
                exp_pv   = 1;
                in_frame = 0;
            end
        end
        @(negedge clk);
        lag_got = longint'(peak_lag);
        lag_exp = (last_idx < NFFT / 2) ? last_idx : last_idx - NFFT;
        check_eq("peak_valid", 64'(peak_valid), 64'(exp_pv));
        check_eq("frame_err", 64'(frame_err), 64'(exp_err));
        check_eq("busy", 64'(busy), 64'(in_frame));
        check_eq("peak_idx", 64'(peak_idx), 64'(last_idx));
        check_eq("peak_lag", 64'(lag_got), 64'(lag_exp));
        check_eq("peak_mag", 64'(peak_mag), 64'(last_mag));
    endtask

    // Send samples [0, count) of fr_*, with optional invalid cycles in between.
    task automatic send_frame(input int count, input int gap_pct);
        for (int k = 0; k < count; k++) begin
            while ($urandom_range(99) < gap_pct)
                send($urandom, $urandom, 1'b0, 1'($urandom_range(1)));
            send(fr_r[k], fr_i[k], 1'b1, k == 0);
        end
    endtask

    task automatic clear_frame();
        for (int k = 0; k < NFFT; k++) begin
            fr_r[k] = '0;
            fr_i[k] = '0;
        end
    endtask

    task automatic rand_frame();
        for (int k = 0; k < NFFT; k++) begin
            fr_r[k] = $urandom;
            fr_i[k] = $urandom;
            if ($urandom_range(15) == 0) fr_r[k] = 32'h8000_0000;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pv"}, 64'(peak_valid), 64'd0);
        check_eq({tag, "_idx"}, 64'(peak_idx), 64'd0);
        check_eq({tag, "_mag"}, 64'(peak_mag), 64'd0);
        check_eq({tag, "_err"}, 64'(frame_err), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_rdr"}, 64'(rd_data_r), 64'd0);
        check_eq({tag, "_rdi"}, 64'(rd_data_i), 64'd0);
    endtask

    task automatic check_read(input int addr);
        rd_addr = AW'(addr);
        @(negedge clk);
`ifdef XCORR_PEAK_BUF_EN
        check_eq("rd_data_r", 64'(rd_data_r), 64'(mem_r[addr]));
        check_eq("rd_data_i", 64'(rd_data_i), 64'(mem_i[addr]));
`else
        check_eq("rd_data_r", 64'(rd_data_r), 64'd0);
        check_eq("rd_data_i", 64'(rd_data_i), 64'd0);
`endif
    endtask

    initial begin
        rst             = 1'b1;
        serial_in_r     = '0;
        serial_in_i     = '0;
        data_valid_IFFT = 1'b0;
        end_IFFT        = 1'b0;
        rd_addr         = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Samples without a start marker while idle are dropped.
        for (int k = 0; k < 5; k++) send($urandom, $urandom, 1'b1, 1'b0);

        // Delta at index 5.
        clear_frame();
        fr_r[5] = 32'h0001_0000;
        send_frame(NFFT, 0);
        check_eq("delta_idx", 64'(peak_idx), 64'd5);

        // Peak in the upper half: -3.0 + 1.0j at index 120 -> lag -8.
        clear_frame();
        fr_r[120] = 32'hFFFD_0000;
        fr_i[120] = 32'h0001_0000;
        send_frame(NFFT, 0);
        check_eq("neg_lag_mag", 64'(peak_mag), 64'h4_0000);

        // Tie between 10 and 40: lowest index wins.
        clear_frame();
        fr_r[10] = 32'h8000; fr_i[10] = 32'h8000;
        fr_r[40] = 32'h8000; fr_i[40] = 32'h8000;
        send_frame(NFFT, 0);
        check_eq("tie_idx", 64'(peak_idx), 64'd10);

        // Most negative value on both parts.
        clear_frame();
        fr_r[77] = 32'h8000_0000; fr_i[77] = 32'h8000_0000;
        send_frame(NFFT, 0);
        check_eq("extreme_mag", 64'(peak_mag), 64'h1_0000_0000);

        // Valid toggled every cycle.
        rand_frame();
        for (int k = 0; k < NFFT; k++) begin
            send(fr_r[k], fr_i[k], 1'b1, k == 0);
            send($urandom, $urandom, 1'b0, 1'($urandom_range(1)));
        end

        // Early restart at cnt=60, then a complete second frame.
        rand_frame();
        send_frame(60, 0);
        rand_frame();
        send_frame(NFFT, 0);

        // Reset in the middle of a frame.
        rand_frame();
        send_frame(30, 10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst      = 1'b0;
        in_frame = 0;
        fq.delete();
        last_idx = 0;
        last_mag = 0;
        for (int k = 0; k < 4; k++) send($urandom, $urandom, 1'b1, 1'b0);

        // Back-to-back frames: the next start marker lands in the result cycle.
        for (int f = 0; f < 3; f++) begin
            rand_frame();
            send_frame(NFFT, 0);
        end

        // Random frames with random gaps.
        for (int f = 0; f < 4; f++) begin
            rand_frame();
            send_frame(NFFT, 30);
            for (int k = 0; k < int'($urandom_range(3)); k++) send($urandom, $urandom, 1'b0, 1'b0);
        end

        // Ramp frame and buffer readback.
        for (int k = 0; k < NFFT; k++) begin
            fr_r[k] = 32'(k);
            fr_i[k] = 32'(NFFT - k);
        end
        send_frame(NFFT, 0);
        data_valid_IFFT = 1'b0;
        end_IFFT        = 1'b0;
        check_read(77);
        check_read(0);
        check_read(NFFT - 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
